ioctl_load_sequencer: RTL and testbench
=======================================

// Module: ioctl_load_sequencer
// PURPOSE
//  Sequences the HPS ioctl download stream into the arcade core. Routes index-0 bytes to the
//  game ROM write port, index-1 to the machine-select (mod) register, and index-254 to the
//  8-byte DIP bank. Owns the core reset: held during and after downloads, and until a valid
//  ROM is present. Sits between hps_io and invaders_top in the emu top level.
// PARAMETERS
//  ROM_AW       16    ROM write address width; bytes at ioctl_addr >= 2**ROM_AW are rejected
//  HOLD_CYCLES  1024  cycles core_reset stays high in HOLD (>=1)
// PORTS
//  clk_sys         in   1      system clock (24 MHz)
//  reset           in   1      synchronous, active-high; clears all state
//  ext_reset_req   in   1      level; user/menu reset request (status[0] | buttons[1])
//  ioctl_download  in   1      download window active
//  ioctl_wr        in   1      byte strobe, one cycle per byte
//  ioctl_addr      in   25     byte address within current index
//  ioctl_dout      in   8      byte data
//  ioctl_index     in   8      stream selector
//  rom_wr          out  1      ROM write strobe (registered)
//  rom_addr        out  ROM_AW ROM write address
//  rom_data        out  8      ROM write data
//  mod             out  8      machine select
//  sw              out  64     DIP bank, sw[8k+7:8k] = byte k
//  core_reset      out  1      reset to game core
//  rom_valid       out  1      a good ROM load has completed
//  load_err        out  1      sticky; last ROM load bad (cleared at next download start)
// BEHAVIOUR
//  Reset values: rom_wr=0, rom_addr=0, rom_data=0, mod=0, sw=0, core_reset=1, rom_valid=0,
//   load_err=0, state=IDLE, hold counter=0, rom byte count=0.
//  States: IDLE (no valid ROM, core_reset=1), LOAD (core_reset=1), HOLD (core_reset=1),
//   RUN (core_reset=0). core_reset is registered and decoded from the next state.
//  Rising edge of ioctl_download (registered compare) from any state -> LOAD. Clears the ROM
//   byte count and load_err only when ioctl_index==0 at that edge.
//  In LOAD, on each ioctl_wr:
//   idx 0: addr[24:ROM_AW]==0 -> rom_wr=1 next cycle, rom_addr/rom_data = sampled addr/data,
//          count++ (saturating); otherwise no write and load_err<=1.
//   idx 1: addr==0 -> mod<=dout; other addresses ignored.
//   idx 254: addr<8 -> sw byte addr[2:0] <= dout; others ignored. Other indices ignored.
//  ioctl_wr while ioctl_download=0 is ignored in every state.
//  Falling edge of ioctl_download in LOAD:
//   if the load was index 0: rom_valid <= (count>0 && !load_err).
//   Other indices leave rom_valid unchanged.
//   Next state: HOLD if the resulting rom_valid=1, else IDLE.
//  HOLD: counter loads HOLD_CYCLES-1 on entry and decrements; at 0 -> RUN. core_reset is
//   high for exactly HOLD_CYCLES cycles in HOLD.
//  ext_reset_req=1 in HOLD or RUN -> (re)enter HOLD with counter reloaded. Ignored in IDLE and
//   LOAD. A level held high keeps the core in HOLD.
//  Same-cycle priority: reset > download rising edge > download falling edge > ext_reset_req
//   > hold countdown.
//  reset mid-download -> IDLE, rom_valid=0. Bytes after reset are ignored until the next
//   rising edge of ioctl_download.
//  rom_wr is asserted only in the cycle after an accepted byte; there is no back-pressure.
// TESTING
//  1. After reset, download idx0 with 4 bytes A5,5A,00,FF at addr 0..3 -> rom_wr x4, each 1
//     cycle after ioctl_wr, with matching addr/data; fall -> HOLD; core_reset low exactly
//     HOLD_CYCLES cycles after the fall register; rom_valid=1.
//  2. idx0 download with addr 0x10000 (ROM_AW=16) -> no rom_wr, load_err=1, rom_valid=0,
//     state IDLE; core_reset stays 1.
//  3. In RUN, idx254 writes addr 2 = 0x3C and addr 9 = 0xEE -> sw[23:16]=0x3C, others 0;
//     core_reset high through the window then HOLD_CYCLES; rom_valid stays 1.
//  4. idx1 write 0x05 at addr 0 and 0x07 at addr 1 -> mod=0x05.
//  5. In RUN, pulse ext_reset_req 1 cycle, then again mid-HOLD -> HOLD restarts; core_reset
//     low HOLD_CYCLES after the second pulse.
//  6. Assert reset midway through an idx0 load -> all outputs at reset values next cycle;
//     remaining ioctl_wr strobes produce no rom_wr.

Source files
------------

// File: rtl/ioctl_load_sequencer.sv
// Steers the hps_io download stream into ROM, machine-select and DIP registers,
// and owns the game core reset across downloads and user reset requests.
module ioctl_load_sequencer #(
  parameter int unsigned ROM_AW      = 16,
  parameter int unsigned HOLD_CYCLES = 1024
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               ext_reset_req,
  input  logic               ioctl_download,
  input  logic               ioctl_wr,
  input  logic [24:0]        ioctl_addr,
  input  logic [7:0]         ioctl_dout,
  input  logic [7:0]         ioctl_index,
  output logic               rom_wr,
  output logic [ROM_AW-1:0]  rom_addr,
  output logic [7:0]         rom_data,
  output logic [7:0]         mod,
  output logic [63:0]        sw,
  output logic               core_reset,
  output logic               rom_valid,
  output logic               load_err
);

  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned CNT_W  = ROM_AW + 1;
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - 1);

  localparam logic [7:0] IDX_ROM = 8'd0;
  localparam logic [7:0] IDX_MOD = 8'd1;
  localparam logic [7:0] IDX_DIP = 8'd254;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_HOLD,
    S_RUN
  } state_t;

  state_t              state_q, state_d;
  logic                dl_q, dl_d;
  logic [7:0]          load_idx_q, load_idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                rom_wr_q, rom_wr_d;
  logic [ROM_AW-1:0]   rom_addr_q, rom_addr_d;
  logic [7:0]          rom_data_q, rom_data_d;
  logic [7:0]          mod_q, mod_d;
  logic [63:0]         sw_q, sw_d;
  logic                core_reset_q, core_reset_d;
  logic                rom_valid_q, rom_valid_d;
  logic                load_err_q, load_err_d;
  logic                dl_rise, dl_fall, byte_ok;

  // Next-state, byte routing and core reset decode
  always_comb begin
    state_d      = state_q;
    dl_d         = ioctl_download;
    load_idx_d   = load_idx_q;
    cnt_d        = cnt_q;
    hold_d       = hold_q;
    rom_wr_d     = 1'b0;
    rom_addr_d   = rom_addr_q;
    rom_data_d   = rom_data_q;
    mod_d        = mod_q;
    sw_d         = sw_q;
    rom_valid_d  = rom_valid_q;
    load_err_d   = load_err_q;

    dl_rise = ioctl_download & ~dl_q;
    dl_fall = ~ioctl_download & dl_q;
    byte_ok = (state_q == S_LOAD) && ioctl_download && ioctl_wr;

    if (byte_ok) begin
      case (ioctl_index)
        IDX_ROM: begin
          if ((ioctl_addr >> ROM_AW) == 25'd0) begin
            rom_wr_d   = 1'b1;
            rom_addr_d = ioctl_addr[ROM_AW-1:0];
            rom_data_d = ioctl_dout;
            if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
          end else begin
            load_err_d = 1'b1;
          end
        end
        IDX_MOD: if (ioctl_addr == 25'd0) mod_d = ioctl_dout;
        IDX_DIP: if (ioctl_addr < 25'd8) sw_d[{ioctl_addr[2:0], 3'b000} +: 8] = ioctl_dout;
        default: ;
      endcase
    end

    if (dl_rise) begin
      state_d    = S_LOAD;
      load_idx_d = ioctl_index;
      if (ioctl_index == IDX_ROM) begin
        cnt_d      = '0;
        load_err_d = 1'b0;
      end
    end else if ((state_q == S_LOAD) && dl_fall) begin
      if (load_idx_q == IDX_ROM) rom_valid_d = (cnt_q != '0) && !load_err_q;
      state_d = rom_valid_d ? S_HOLD : S_IDLE;
      hold_d  = HOLD_RELOAD;
    end else if (ext_reset_req && ((state_q == S_HOLD) || (state_q == S_RUN))) begin
      state_d = S_HOLD;
      hold_d  = HOLD_RELOAD;
    end else if (state_q == S_HOLD) begin
      if (hold_q == '0) state_d = S_RUN;
      else              hold_d  = hold_q - HOLD_W'(1);
    end

    core_reset_d = (state_d != S_RUN);
  end

  // dl_q resets high so a download still active across reset is not seen as a new edge
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= S_IDLE;
      dl_q         <= 1'b1;
      load_idx_q   <= '0;
      cnt_q        <= '0;
      hold_q       <= '0;
      rom_wr_q     <= 1'b0;
      rom_addr_q   <= '0;
      rom_data_q   <= '0;
      mod_q        <= '0;
      sw_q         <= '0;
      core_reset_q <= 1'b1;
      rom_valid_q  <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      dl_q         <= dl_d;
      load_idx_q   <= load_idx_d;
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
      rom_wr_q     <= rom_wr_d;
      rom_addr_q   <= rom_addr_d;
      rom_data_q   <= rom_data_d;
      mod_q        <= mod_d;
      sw_q         <= sw_d;
      core_reset_q <= core_reset_d;
      rom_valid_q  <= rom_valid_d;
      load_err_q   <= load_err_d;
    end
  end

  assign rom_wr     = rom_wr_q;
  assign rom_addr   = rom_addr_q;
  assign rom_data   = rom_data_q;
  assign mod        = mod_q;
  assign sw         = sw_q;
  assign core_reset = core_reset_q;
  assign rom_valid  = rom_valid_q;
  assign load_err   = load_err_q;

endmodule

// File: tb/tb_ioctl_load_sequencer.sv
// Directed vector bench for ioctl_load_sequencer with a short hold time.
module tb_ioctl_load_sequencer;

  localparam int unsigned ROM_AW = 16;
  localparam int unsigned HOLD   = 8;

  logic        clk = 1'b0;
  logic        reset, ext_reset_req, ioctl_download, ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout, ioctl_index;
  logic        rom_wr, core_reset, rom_valid, load_err;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data, mod;
  logic [63:0] sw;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ioctl_load_sequencer #(.ROM_AW(ROM_AW), .HOLD_CYCLES(HOLD)) dut (
    .clk_sys(clk), .reset(reset), .ext_reset_req(ext_reset_req),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index), .rom_wr(rom_wr),
    .rom_addr(rom_addr), .rom_data(rom_data), .mod(mod), .sw(sw),
    .core_reset(core_reset), .rom_valid(rom_valid), .load_err(load_err)
  );

  typedef struct {
    logic        rst, dl, wr, ext;
    logic [7:0]  idx;
    logic [24:0] addr;
    logic [7:0]  dout;
    logic        e_wr;
    logic [15:0] e_addr;
    logic [7:0]  e_data;
    logic        e_crst, e_valid, e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic dl, logic wr, logic ext, logic [7:0] idx,
                              logic [24:0] addr, logic [7:0] dout, logic e_wr,
                              logic [15:0] e_addr, logic [7:0] e_data, logic e_crst,
                              logic e_valid, logic e_err);
    vec_t v;
    v.rst = rst; v.dl = dl; v.wr = wr; v.ext = ext; v.idx = idx; v.addr = addr;
    v.dout = dout; v.e_wr = e_wr; v.e_addr = e_addr; v.e_data = e_data;
    v.e_crst = e_crst; v.e_valid = e_valid; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0; ext_reset_req = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0; ioctl_index = '0;
  endtask

  task automatic run_vecs(input int a, input int b);
    for (int i = a; i < b; i++) begin
      reset = tbl[i].rst; ioctl_download = tbl[i].dl; ioctl_wr = tbl[i].wr;
      ext_reset_req = tbl[i].ext; ioctl_index = tbl[i].idx;
      ioctl_addr = tbl[i].addr; ioctl_dout = tbl[i].dout;
      step();
      chk($sformatf("v%0d_rom_wr", i),     64'(rom_wr),     64'(tbl[i].e_wr));
      chk($sformatf("v%0d_rom_addr", i),   64'(rom_addr),   64'(tbl[i].e_addr));
      chk($sformatf("v%0d_rom_data", i),   64'(rom_data),   64'(tbl[i].e_data));
      chk($sformatf("v%0d_core_reset", i), 64'(core_reset), 64'(tbl[i].e_crst));
      chk($sformatf("v%0d_rom_valid", i),  64'(rom_valid),  64'(tbl[i].e_valid));
      chk($sformatf("v%0d_load_err", i),   64'(load_err),   64'(tbl[i].e_err));
    end
  endtask

  // Counts cycles from HOLD entry until core_reset drops, with a cycle budget
  task automatic expect_hold(input string nm, input int exp);
    int n;
    n = 0;
    idle_inputs();
    while (core_reset === 1'b1 && n < 64) begin
      step();
      n++;
    end
    chk(nm, 64'(n), 64'(exp));
  endtask

  initial begin
    // rst dl wr ext idx addr dout | e_wr e_addr e_data crst valid err
    tbl.push_back(mk(1,0,0,0,8'd0,  25'h0,     8'h00, 0,16'h0000,8'h00,1,0,0)); // 0
    tbl.push_back(mk(1,0,0,0,8'd0,  25'h0,     8'h00, 0,16'h0000,8'h00,1,0,0));
    tbl.push_back(mk(0,0,0,0,8'd0,  25'h0,     8'h00, 0,16'h0000,8'h00,1,0,0));
    tbl.push_back(mk(0,1,0,0,8'd0,  25'h0,     8'h00, 0,16'h0000,8'h00,1,0,0));
    tbl.push_back(mk(0,1,1,0,8'd0,  25'h0,     8'hA5, 1,16'h0000,8'hA5,1,0,0));
    tbl.push_back(mk(0,1,0,0,8'd0,  25'h0,     8'h00, 0,16'h0000,8'hA5,1,0,0)); // 5
    tbl.push_back(mk(0,1,1,0,8'd0,  25'h1,     8'h5A, 1,16'h0001,8'h5A,1,0,0));
    tbl.push_back(mk(0,1,1,0,8'd0,  25'h2,     8'h00, 1,16'h0002,8'h00,1,0,0));
    tbl.push_back(mk(0,1,1,0,8'd0,  25'h3,     8'hFF, 1,16'h0003,8'hFF,1,0,0));
    tbl.push_back(mk(0,1,0,0,8'd0,  25'h0,     8'h00, 0,16'h0003,8'hFF,1,0,0));
    tbl.push_back(mk(0,0,0,0,8'd0,  25'h0,     8'h00, 0,16'h0003,8'hFF,1,1,0)); // 10
    tbl.push_back(mk(0,1,0,0,8'd0,  25'h0,     8'h00, 0,16'h0003,8'hFF,1,1,0));
    tbl.push_back(mk(0,1,1,0,8'd0,  25'h10000, 8'h77, 0,16'h0003,8'hFF,1,1,1));
    tbl.push_back(mk(0,1,0,0,8'd0,  25'h0,     8'h00, 0,16'h0003,8'hFF,1,1,1));
    tbl.push_back(mk(0,0,0,0,8'd0,  25'h0,     8'h00, 0,16'h0003,8'hFF,1,0,1));
    tbl.push_back(mk(0,0,1,0,8'd0,  25'h5,     8'h55, 0,16'h0003,8'hFF,1,0,1)); // 15
    tbl.push_back(mk(0,1,0,0,8'd0,  25'h0,     8'h00, 0,16'h0003,8'hFF,1,0,0));
    tbl.push_back(mk(0,1,1,0,8'd0,  25'hFFFF,  8'h11, 1,16'hFFFF,8'h11,1,0,0));
    tbl.push_back(mk(0,0,0,0,8'd0,  25'h0,     8'h00, 0,16'hFFFF,8'h11,1,1,0));
    tbl.push_back(mk(0,1,0,0,8'd254,25'h0,     8'h00, 0,16'hFFFF,8'h11,1,1,0));
    tbl.push_back(mk(0,1,1,0,8'd254,25'h2,     8'h3C, 0,16'hFFFF,8'h11,1,1,0)); // 20
    tbl.push_back(mk(0,1,1,0,8'd254,25'h9,     8'hEE, 0,16'hFFFF,8'h11,1,1,0));
    tbl.push_back(mk(0,0,0,0,8'd254,25'h0,     8'h00, 0,16'hFFFF,8'h11,1,1,0));
    tbl.push_back(mk(0,1,0,0,8'd1,  25'h0,     8'h00, 0,16'hFFFF,8'h11,1,1,0));
    tbl.push_back(mk(0,1,1,0,8'd1,  25'h0,     8'h05, 0,16'hFFFF,8'h11,1,1,0));
    tbl.push_back(mk(0,1,1,0,8'd1,  25'h1,     8'h07, 0,16'hFFFF,8'h11,1,1,0)); // 25
    tbl.push_back(mk(0,0,0,0,8'd1,  25'h0,     8'h00, 0,16'hFFFF,8'h11,1,1,0));
    tbl.push_back(mk(0,1,0,0,8'd0,  25'h0,     8'h00, 0,16'hFFFF,8'h11,1,1,0));
    tbl.push_back(mk(0,1,1,0,8'd0,  25'h0,     8'h99, 1,16'h0000,8'h99,1,1,0));
    tbl.push_back(mk(1,1,1,0,8'd0,  25'h1,     8'h98, 0,16'h0000,8'h00,1,0,0));
    tbl.push_back(mk(0,1,1,0,8'd0,  25'h2,     8'h97, 0,16'h0000,8'h00,1,0,0)); // 30
    tbl.push_back(mk(0,1,1,0,8'd0,  25'h3,     8'h96, 0,16'h0000,8'h00,1,0,0));
    tbl.push_back(mk(0,0,0,0,8'd0,  25'h0,     8'h00, 0,16'h0000,8'h00,1,0,0));
    tbl.push_back(mk(0,0,0,1,8'd0,  25'h0,     8'h00, 0,16'h0000,8'h00,1,0,0));

    idle_inputs();
    reset = 1'b1;

    // Reset state and a clean 4-byte ROM load
    run_vecs(0, 11);
    chk("reset_mod", 64'(mod), 64'h0);
    chk("reset_sw", sw, 64'h0);
    expect_hold("hold_after_rom", HOLD);

    // Out-of-range ROM byte, then a good single-byte load at the top address
    run_vecs(11, 19);
    expect_hold("hold_after_reload", HOLD);

    // DIP bank download while running
    run_vecs(19, 23);
    chk("sw_bank", sw, 64'h0000_0000_003C_0000);
    expect_hold("hold_after_dip", HOLD);

    // Machine select download
    run_vecs(23, 27);
    chk("mod_value", 64'(mod), 64'h05);
    expect_hold("hold_after_mod", HOLD);

    // ext_reset_req pulse, restart mid-hold, then a held level
    chk("run_core_reset", 64'(core_reset), 64'h0);
    ext_reset_req = 1'b1;
    step();
    chk("ext_pulse_core_reset", 64'(core_reset), 64'h1);
    ext_reset_req = 1'b0;
    repeat (3) step();
    chk("mid_hold_core_reset", 64'(core_reset), 64'h1);
    ext_reset_req = 1'b1;
    step();
    expect_hold("ext_restart_hold", HOLD);
    ext_reset_req = 1'b1;
    repeat (12) step();
    chk("ext_level_core_reset", 64'(core_reset), 64'h1);
    expect_hold("ext_level_hold", HOLD);
    chk("ext_rom_valid", 64'(rom_valid), 64'h1);

    // Reset in the middle of an index-0 load
    run_vecs(27, 34);
    chk("post_reset_mod", 64'(mod), 64'h0);
    chk("post_reset_sw", sw, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
